// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
package uart_pkg;

  typedef enum logic {IDLE, BUSY} txq_state_t;

  localparam int TXQ_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a combinational head output and a separately held
// occupancy count. Pushes into a full FIFO and pops from an empty FIFO are
// ignored. Flush empties the FIFO and takes priority over push and pop.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against the registered full/empty flags.
  always_comb begin
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter. Bytes are buffered in a FIFO and
// launched one at a time with a single-cycle trmt pulse; the next byte goes
// out in the first cycle tx_done reads high, so frames are back-to-back.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = TXQ_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     tx_done,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy
);

  txq_state_t state_q;
  txq_state_t state_d;
  logic [7:0] head;
  logic       can_launch;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (trmt),
    .flush (flush),
    .din   (wr_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A byte is available for launch unless the queue is being flushed.
  assign can_launch = !empty && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: leave BUSY only when the frame ends with nothing to follow.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (can_launch) state_d = BUSY;
      BUSY: if (tx_done && !can_launch) state_d = IDLE;
    endcase
  end

  // Launch outputs; tx_done is ignored in IDLE because it is sticky there.
  always_comb begin
    trmt    = can_launch && ((state_q == IDLE) || tx_done);
    tx_data = trmt ? head : '0;
    busy    = (state_q == BUSY);
  end

  // Sticky overflow: set on a dropped write, cleared by flush.
  always_ff @(posedge clk) begin
    if (!rst_n || flush)   overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

endmodule
